i2c_reg_ctrl: RTL and testbench
===============================

// Module: i2c_reg_ctrl
// PURPOSE
//  Sequences register-file accesses from the I2C slave byte stream in led_driver.
//  Sits between the I2C bus interface (byte/START/STOP events) and the LED register
//  block: first write byte loads the register pointer, later bytes write/read
//  registers with pointer auto-increment. Pointer persists across repeated START.
// PARAMETERS
//  ADDR_W    3  register pointer width
//  DATA_W    8  register data width
//  NUM_REGS  8  implemented registers; pointer wraps NUM_REGS-1 -> 0
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  bus_start   in   1       1-cycle pulse: START or repeated START seen
//  bus_stop    in   1       1-cycle pulse: STOP seen
//  addr_match  in   1       1-cycle pulse: slave address byte matched
//  bus_rw      in   1       R/W bit, valid with addr_match (1 = read)
//  rx_byte     in   DATA_W  received data byte
//  rx_valid    in   1       1-cycle pulse: rx_byte valid
//  tx_req      in   1       1-cycle pulse: interface needs next read byte
//  reg_rdata   in   DATA_W  register read data, valid 1 cycle after reg_read
//  reg_addr    out  ADDR_W  register address (= pointer)
//  reg_wdata   out  DATA_W  register write data
//  reg_write   out  1       1-cycle write strobe
//  reg_read    out  1       1-cycle read strobe
//  tx_byte     out  DATA_W  byte to shift out on read
//  tx_valid    out  1       tx_byte valid
//  nack_req    out  1       request NACK on current byte (bad pointer)
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0; reg_write/reg_read/tx_valid/nack_req=0; tx_byte=0, reg_wdata=0.
//  States: IDLE, PTR, WDATA, WDROP, RWAIT, RFETCH.
//  - IDLE: addr_match&!bus_rw -> PTR; addr_match&bus_rw -> RWAIT.
//  - PTR: rx_valid: byte<NUM_REGS -> ptr=byte[ADDR_W-1:0], -> WDATA;
//    byte>=NUM_REGS -> ptr unchanged, nack_req=1 (held until STOP/START), -> WDROP.
//  - WDATA: rx_valid -> next cycle reg_write=1 (1 cycle), reg_addr=ptr, reg_wdata=byte;
//    ptr increments (wrap) on the edge ending the strobe. Back-to-back bytes OK.
//  - WDROP: rx_valid ignored, no strobes.
//  - RWAIT: tx_req -> RFETCH; tx_valid cleared same edge.
//  - RFETCH: reg_read=1 one cycle, reg_addr=ptr; next edge tx_byte<=reg_rdata, tx_valid=1,
//    ptr increments (wrap), -> RWAIT. Latency tx_req -> tx_valid = 2 cycles.
//  - tx_valid stays high until next tx_req, bus_start, bus_stop or reset.
//  - bus_start (any state): -> IDLE, ptr retained, nack_req/tx_valid cleared.
//  - bus_stop (any state): -> IDLE, same as START; priority over rx_valid/tx_req same cycle
//    (byte discarded, no strobe). A pending reg_write already scheduled still completes.
//  - addr_match outside IDLE: treated as IDLE entry (covers missed START).
//  - reg_write and reg_read never asserted in the same cycle.
//  - reg_addr = ptr at all times when no strobe pending.
// TESTING
//  - Write 0x02,0xAA,0x55 -> reg_write @addr2=0xAA then @addr3=0x55; ptr ends 4.
//  - Write 0x07,0x11,0x22 -> writes @7=0x11, @0=0x22 (wrap); ptr ends 1.
//  - Write ptr 0x05, rep-START read, 2 tx_req -> reg_read @5,@6; tx_byte=rdata, 2-cycle latency.
//  - NUM_REGS=6, ptr byte 0x06 -> nack_req=1, following 0x33 gives no reg_write; STOP clears.
//  - bus_stop with rx_valid same cycle in WDATA -> no reg_write, state IDLE, ptr unchanged.
//  - reset asserted in RFETCH -> next cycle all outputs 0, ptr=0, state IDLE.

Source files
------------

// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer between the I2C slave byte interface and the LED register block.
// The first write byte sets the pointer; later bytes write or read registers with auto-increment.
module i2c_reg_ctrl #(
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bus_start,
   input  logic              bus_stop,
   input  logic              addr_match,
   input  logic              bus_rw,
   input  logic [DATA_W-1:0] rx_byte,
   input  logic              rx_valid,
   input  logic              tx_req,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_write,
   output logic              reg_read,
   output logic [DATA_W-1:0] tx_byte,
   output logic              tx_valid,
   output logic              nack_req
);

   typedef enum logic [2:0] {IDLE, PTR, WDATA, WDROP, RWAIT, RFETCH} state_t;

   localparam logic [DATA_W-1:0] NREGS_B  = DATA_W'(NUM_REGS);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_REGS - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_inc;
   logic              bus_clr, ptr_ok, ptr_load, wr_sched, nack_set, rd_done;

   assign ptr_inc  = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
   assign reg_addr = ptr;
   assign reg_read = (state == RFETCH);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // START/STOP win over everything; a stray address match restarts the transfer.
   always_comb begin
      state_n  = state;
      ptr_load = 1'b0;
      wr_sched = 1'b0;
      nack_set = 1'b0;
      rd_done  = 1'b0;
      bus_clr  = bus_start | bus_stop | addr_match;
      ptr_ok   = (rx_byte < NREGS_B);
      if (bus_start || bus_stop) begin
         state_n = IDLE;
      end else if (addr_match) begin
         state_n = bus_rw ? RWAIT : PTR;
      end else begin
         case (state)
            PTR: begin
               if (rx_valid) begin
                  if (ptr_ok) begin
                     ptr_load = 1'b1;
                     state_n  = WDATA;
                  end else begin
                     nack_set = 1'b1;
                     state_n  = WDROP;
                  end
               end
            end
            WDATA:  wr_sched = rx_valid;
            RWAIT:  if (tx_req) state_n = RFETCH;
            RFETCH: begin
               rd_done = 1'b1;
               state_n = RWAIT;
            end
            default: ;
         endcase
      end
   end

   // Read data is sampled on the edge that ends the read strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         reg_write <= 1'b0;
         reg_wdata <= '0;
         tx_byte   <= '0;
         tx_valid  <= 1'b0;
         nack_req  <= 1'b0;
      end else begin
         reg_write <= wr_sched;
         if (wr_sched) reg_wdata <= rx_byte;

         if (ptr_load)                  ptr <= rx_byte[ADDR_W-1:0];
         else if (reg_write || rd_done) ptr <= ptr_inc;

         if (bus_clr) begin
            tx_valid <= 1'b0;
         end else if (rd_done) begin
            tx_valid <= 1'b1;
            tx_byte  <= reg_rdata;
         end else if (tx_req) begin
            tx_valid <= 1'b0;
         end

         if (bus_clr)       nack_req <= 1'b0;
         else if (nack_set) nack_req <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: directed scenarios then random bus traffic against a transaction-level model.
module tb_i2c_reg_ctrl;
   logic       clk = 1'b0;
   logic       reset, bus_start, bus_stop, addr_match, bus_rw, rx_valid, tx_req;
   logic [7:0] rx_byte, reg_rdata, reg_wdata, tx_byte;
   logic [2:0] reg_addr;
   logic       reg_write, reg_read, tx_valid, nack_req;

   logic [2:0] u6_reg_addr;
   logic [7:0] u6_reg_wdata, u6_tx_byte;
   logic       u6_reg_write, u6_reg_read, u6_tx_valid, u6_nack_req;

   int total = 0;
   int bad   = 0;
   int u6_wr_cnt = 0;

   always #5 clk = ~clk;

   i2c_reg_ctrl #(.ADDR_W(3), .DATA_W(8), .NUM_REGS(8)) dut (
      .clk(clk), .reset(reset), .bus_start(bus_start), .bus_stop(bus_stop),
      .addr_match(addr_match), .bus_rw(bus_rw), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .tx_req(tx_req), .reg_rdata(reg_rdata), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_write(reg_write), .reg_read(reg_read), .tx_byte(tx_byte), .tx_valid(tx_valid),
      .nack_req(nack_req));

   i2c_reg_ctrl #(.ADDR_W(3), .DATA_W(8), .NUM_REGS(6)) u6 (
      .clk(clk), .reset(reset), .bus_start(bus_start), .bus_stop(bus_stop),
      .addr_match(addr_match), .bus_rw(bus_rw), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .tx_req(tx_req), .reg_rdata(8'h00), .reg_addr(u6_reg_addr), .reg_wdata(u6_reg_wdata),
      .reg_write(u6_reg_write), .reg_read(u6_reg_read), .tx_byte(u6_tx_byte),
      .tx_valid(u6_tx_valid), .nack_req(u6_nack_req));

   // Register block behind the main instance.
   logic [7:0] mem [8];
   assign reg_rdata = mem[reg_addr];
   always @(posedge clk) begin
      if (reg_write) mem[reg_addr] <= reg_wdata;
      if (u6_reg_write) u6_wr_cnt <= u6_wr_cnt + 1;
   end

   // Transaction-level model
   localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_DROP = 3, M_RD = 4;
   logic [7:0] mregs [8];
   int         m_ptr  = 0;
   int         m_mode = M_IDLE;
   bit         m_nack = 1'b0;
   bit         m_txv  = 1'b0;
   logic [7:0] m_txb  = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".addr"}, 32'(reg_addr), 32'(m_ptr));
      chk({tag, ".nack"}, 32'(nack_req), 32'(m_nack));
      chk({tag, ".txv"}, 32'(tx_valid), 32'(m_txv));
      chk({tag, ".wr"}, 32'(reg_write), 0);
      chk({tag, ".rd"}, 32'(reg_read), 0);
      if (m_txv) chk({tag, ".txb"}, 32'(tx_byte), 32'(m_txb));
   endtask

   task automatic op_start();
      bus_start = 1'b1; tick(); bus_start = 1'b0;
      m_mode = M_IDLE; m_nack = 1'b0; m_txv = 1'b0;
      check_outs("start");
   endtask

   task automatic op_stop();
      bus_stop = 1'b1; tick(); bus_stop = 1'b0;
      m_mode = M_IDLE; m_nack = 1'b0; m_txv = 1'b0;
      check_outs("stop");
   endtask

   task automatic op_addr(input bit rw);
      addr_match = 1'b1; bus_rw = rw; tick(); addr_match = 1'b0;
      m_mode = rw ? M_RD : M_PTR; m_nack = 1'b0; m_txv = 1'b0;
      check_outs("addr");
   endtask

   task automatic op_byte(input logic [7:0] b);
      rx_byte = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
      if (m_mode == M_PTR) begin
         chk("ptrbyte.wr", 32'(reg_write), 0);
         if (b < 8) begin m_ptr = b; m_mode = M_WR; end
         else begin m_nack = 1'b1; m_mode = M_DROP; end
      end else if (m_mode == M_WR) begin
         chk("wr.strobe", 32'(reg_write), 1);
         chk("wr.addr", 32'(reg_addr), 32'(m_ptr));
         chk("wr.data", 32'(reg_wdata), 32'(b));
         chk("wr.noread", 32'(reg_read), 0);
         mregs[m_ptr] = b;
         m_ptr = (m_ptr + 1) % 8;
      end else begin
         chk("byte.nowr", 32'(reg_write), 0);
      end
      tick();
      check_outs("byte");
   endtask

   task automatic op_read();
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      m_txv = 1'b0;
      if (m_mode == M_RD) begin
         chk("rd.strobe", 32'(reg_read), 1);
         chk("rd.addr", 32'(reg_addr), 32'(m_ptr));
         chk("rd.txv_clr", 32'(tx_valid), 0);
         chk("rd.nowr", 32'(reg_write), 0);
         tick();
         m_txv = 1'b1;
         m_txb = mregs[m_ptr];
         m_ptr = (m_ptr + 1) % 8;
      end
      check_outs("read");
   endtask

   initial begin
      logic [7:0] b1, b2;
      reset = 1'b1; bus_start = 1'b0; bus_stop = 1'b0; addr_match = 1'b0; bus_rw = 1'b0;
      rx_byte = 8'h00; rx_valid = 1'b0; tx_req = 1'b0;
      tick(); tick();
      chk("rst.addr", 32'(reg_addr), 0);
      chk("rst.wr", 32'(reg_write), 0);
      chk("rst.rd", 32'(reg_read), 0);
      chk("rst.txv", 32'(tx_valid), 0);
      chk("rst.nack", 32'(nack_req), 0);
      chk("rst.txb", 32'(tx_byte), 0);
      chk("rst.wdata", 32'(reg_wdata), 0);
      reset = 1'b0;

      // Six-register instance rejects pointer 6; eight-register instance accepts it.
      op_start(); op_addr(1'b0); op_byte(8'h06);
      chk("n6.nack", 32'(u6_nack_req), 1);
      chk("n6.addr", 32'(u6_reg_addr), 0);
      op_byte(8'h33);
      chk("n6.nowr", 32'(u6_wr_cnt), 0);
      chk("n6.wdata", 32'(u6_reg_wdata), 0);
      chk("n6.misc", 32'({u6_reg_read, u6_tx_valid, u6_tx_byte}), 0);
      op_stop();
      chk("n6.stopclr", 32'(u6_nack_req), 0);

      // Fill every register through the bus
      op_start(); op_addr(1'b0); op_byte(8'h00);
      for (int i = 0; i < 8; i++) op_byte(8'($urandom));
      op_stop();

      // Pointer 8 is out of range here
      op_start(); op_addr(1'b0); op_byte(8'h08);
      chk("n8.nack", 32'(nack_req), 1);
      op_byte(8'h44);
      op_stop();

      op_start(); op_addr(1'b0); op_byte(8'h02); op_byte(8'hAA); op_byte(8'h55);
      chk("seq1.ptr", 32'(reg_addr), 4);
      op_stop();

      op_start(); op_addr(1'b0); op_byte(8'h07); op_byte(8'h11); op_byte(8'h22);
      chk("wrap.ptr", 32'(reg_addr), 1);
      op_stop();

      op_start(); op_addr(1'b0); op_byte(8'h05);
      op_start(); op_addr(1'b1); op_read(); op_read();
      chk("rs.ptr", 32'(reg_addr), 7);
      chk("rs.hold", 32'(tx_valid), 1);
      op_stop();

      // Back-to-back data bytes
      b1 = 8'($urandom); b2 = 8'($urandom);
      op_start(); op_addr(1'b0); op_byte(8'h01);
      rx_byte = b1; rx_valid = 1'b1; tick();
      chk("b2b.wr1", 32'({reg_write, reg_addr, reg_wdata}), 32'({1'b1, 3'd1, b1}));
      rx_byte = b2; tick(); rx_valid = 1'b0;
      chk("b2b.wr2", 32'({reg_write, reg_addr, reg_wdata}), 32'({1'b1, 3'd2, b2}));
      mregs[1] = b1; mregs[2] = b2; m_ptr = 3;
      tick();
      check_outs("b2b.end");

      // STOP together with a data byte drops the byte
      op_start(); op_addr(1'b0); op_byte(8'h03);
      rx_byte = 8'h9C; rx_valid = 1'b1; bus_stop = 1'b1; tick();
      rx_valid = 1'b0; bus_stop = 1'b0;
      chk("stoprx.nowr", 32'(reg_write), 0);
      m_mode = M_IDLE; m_nack = 1'b0; m_txv = 1'b0;
      tick();
      check_outs("stoprx");
      chk("stoprx.ptr", 32'(reg_addr), 3);
      op_byte(8'h12);

      // Reset during the read fetch
      op_start(); op_addr(1'b1);
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      chk("rstrd.rd", 32'(reg_read), 1);
      reset = 1'b1; tick();
      chk("rstrd.outs", 32'({reg_write, reg_read, tx_valid, nack_req}), 0);
      chk("rstrd.addr", 32'(reg_addr), 0);
      chk("rstrd.data", 32'({tx_byte, reg_wdata}), 0);
      reset = 1'b0;
      m_ptr = 0; m_mode = M_IDLE; m_nack = 1'b0; m_txv = 1'b0; m_txb = 8'h00;

      for (int n = 0; n < 400; n++) begin
         int r;
         logic [7:0] b;
         r = int'($urandom_range(0, 9));
         b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
         if (r == 0)                        op_start();
         else if (r == 1)                   op_stop();
         else if (r == 2)                   op_addr(1'($urandom));
         else if (r >= 7 && m_mode == M_RD) op_read();
         else                               op_byte(b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
